// File: rtl/vreg_port_responder_pkg.sv
// Shared types and sizes for the vector register port responder: request
// struct, access/stride encodings, register pointer type and FSM state codes.
package vreg_port_responder_pkg;

  localparam int NUM_OF_LANES      = 2;
  localparam int VECTOR_REG_WIDTH  = 8;
  localparam int NUM_OF_VECTOR_REG = 8;

  // Request data carries either write data or, for strided reads, the stride.
  localparam int REQ_DATA_W = 32;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_t;

  typedef enum logic {
    NON_STRIDE = 1'b0,
    STRIDE     = 1'b1
  } stride_type_t;

  typedef logic [$clog2(NUM_OF_VECTOR_REG)-1:0] v_register_t;

  typedef struct packed {
    logic                  vld;
    access_type_t          access_type;
    logic [31:0]           access_length;
    stride_type_t          stride_type;
    v_register_t           vec_reg_ptr;
    logic [31:0]           addr;
    logic [REQ_DATA_W-1:0] data;
  } cntrl_req_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // A zero-length read still returns one beat.
  function automatic logic [31:0] burst_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/vreg_port_if.sv
// Per-port request/response bundle between requesters (master) and the
// register responder (slave); dbg_state exposes each port's FSM state.
interface vreg_port_if
  import vreg_port_responder_pkg::*;
#(
  parameter int NUM_PORTS = NUM_OF_LANES,
  parameter int ELEM_W    = VECTOR_REG_WIDTH
);

  // Handshake: a request on port i is taken in any cycle where
  // req[i].vld && reg_req_grant[i] at the rising edge; read beats follow on
  // reg_rsp_vld/reg_rsp_data with no back-pressure from the requester.
  cntrl_req_t           req           [NUM_PORTS];
  logic                 reg_req_grant [NUM_PORTS];
  logic                 reg_rsp_vld   [NUM_PORTS];
  logic [ELEM_W-1:0]    reg_rsp_data  [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_busy;
  logic [0:0]           dbg_state     [NUM_PORTS];

  modport master (
    output req,
    input  reg_req_grant,
    input  reg_rsp_vld,
    input  reg_rsp_data,
    input  port_busy,
    input  dbg_state
  );

  modport slave (
    input  req,
    output reg_req_grant,
    output reg_rsp_vld,
    output reg_rsp_data,
    output port_busy,
    output dbg_state
  );

endinterface

// File: rtl/vreg_port_responder_fsm.sv
// vreg_port_fsm: one request port. Captures a request when granted, turns a
// write into a single-cycle write strobe and a read into a strided beat burst.
module vreg_port_fsm
  import vreg_port_responder_pkg::*;
#(
  parameter int ELEM_W   = VECTOR_REG_WIDTH,
  parameter int NUM_VREG = NUM_OF_VECTOR_REG,
  parameter int VLEN     = 64,
  localparam int IDX_W   = $clog2(VLEN),
  localparam int REG_W   = $clog2(NUM_VREG),
  localparam int ADDR_W  = REG_W + IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  cntrl_req_t        req,
  output logic              grant,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ELEM_W-1:0] wr_data,
  output logic              rd_vld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic [0:0]        state
);

  logic [0:0]       state_q, state_d;
  logic [REG_W-1:0] reg_q,   reg_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] step_q,  step_d;
  logic [31:0]      len_q,   len_d;
  logic [31:0]      cnt_q,   cnt_d;

  logic             accept;
  logic             last_beat;
  logic [REG_W-1:0] req_reg;
  logic             unused_req;

  assign unused_req = ^req;
  assign req_reg    = REG_W'(req.vec_reg_ptr);
  assign accept     = grant && req.vld;
  assign last_beat  = (cnt_q == (len_q - 32'd1));

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    idx_d   = idx_q;
    step_d  = step_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (req.access_type == READ_REQ)) begin
          state_d = ST_BURST;
          reg_d   = req_reg;
          idx_d   = req.addr[IDX_W-1:0];
          step_d  = (req.stride_type == STRIDE) ? req.data[IDX_W-1:0] : IDX_W'(1);
          len_d   = burst_len(req.access_length);
          cnt_d   = 32'd0;
        end
      end
      ST_BURST: begin
        // Index width equals log2(VLEN), so the add wraps modulo VLEN.
        idx_d = idx_q + step_q;
        cnt_d = cnt_q + 32'd1;
        if (last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes land at the acceptance edge straight from the request fields.
  assign grant   = ready && (state_q == ST_IDLE);
  assign wr_en   = accept && (req.access_type == WRITE_REQ);
  assign wr_addr = {req_reg, req.addr[IDX_W-1:0]};
  assign wr_data = ELEM_W'(req.data);
  assign rd_vld  = (state_q == ST_BURST);
  assign rd_addr = {reg_q, idx_q};
  assign busy    = (state_q == ST_BURST);
  assign state   = state_q;

endmodule

// File: rtl/vreg_port_responder.sv
// Multi-port vector register file with per-port burst read FSMs.
// Optional VREG_WR_BYPASS_EN forwards same-cycle writes into read beats.
module vreg_port_responder
  import vreg_port_responder_pkg::*;
#(
  parameter int NUM_PORTS = NUM_OF_LANES,
  parameter int ELEM_W    = VECTOR_REG_WIDTH,
  parameter int NUM_VREG  = NUM_OF_VECTOR_REG,
  parameter int VLEN      = 64
) (
  input  logic       clk,
  input  logic       reset,
  vreg_port_if.slave port_if
);

  localparam int IDX_W  = $clog2(VLEN);
  localparam int REG_W  = $clog2(NUM_VREG);
  localparam int ADDR_W = REG_W + IDX_W;
  localparam int DEPTH  = NUM_VREG * VLEN;

  logic                         ready_q, ready_d;
  logic [DEPTH-1:0][ELEM_W-1:0] mem_q, mem_d;

  logic              grant   [NUM_PORTS];
  logic              wr_en   [NUM_PORTS];
  logic [ADDR_W-1:0] wr_addr [NUM_PORTS];
  logic [ELEM_W-1:0] wr_data [NUM_PORTS];
  logic              rd_vld  [NUM_PORTS];
  logic [ADDR_W-1:0] rd_addr [NUM_PORTS];
  logic              busy    [NUM_PORTS];
  logic [0:0]        state   [NUM_PORTS];
  logic [ELEM_W-1:0] rd_word;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    vreg_port_fsm #(
      .ELEM_W   (ELEM_W),
      .NUM_VREG (NUM_VREG),
      .VLEN     (VLEN)
    ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .ready   (ready_q),
      .req     (port_if.req[g]),
      .grant   (grant[g]),
      .wr_en   (wr_en[g]),
      .wr_addr (wr_addr[g]),
      .wr_data (wr_data[g]),
      .rd_vld  (rd_vld[g]),
      .rd_addr (rd_addr[g]),
      .busy    (busy[g]),
      .state   (state[g])
    );
  end

  // Grants open only once a clock edge has been seen out of reset.
  assign ready_d = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Ascending port order lets the highest colliding port's write win.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) begin
        mem_d[wr_addr[p]] = wr_data[p];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_word           = '0;
    port_if.port_busy = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word = mem_q[rd_addr[p]];
`ifdef VREG_WR_BYPASS_EN
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (wr_en[q] && (wr_addr[q] == rd_addr[p])) begin
          rd_word = wr_data[q];
        end
      end
`endif
      port_if.reg_req_grant[p] = grant[p];
      port_if.reg_rsp_vld[p]   = rd_vld[p];
      port_if.reg_rsp_data[p]  = rd_vld[p] ? rd_word : '0;
      port_if.port_busy[p]     = busy[p];
      port_if.dbg_state[p]     = state[p];
    end
  end

endmodule

// File: tb/tb_vreg_port_responder.sv
// Directed bench for vreg_port_responder: drivers push expected read beats
// (data and cycle) into per-port queues, a negedge monitor pops and compares.
module tb_vreg_port_responder;
  import vreg_port_responder_pkg::*;

  localparam int NP    = 2;
  localparam int W     = 8;
  localparam int EXP_W = 32 + W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  logic [EXP_W-1:0] exp_q [NP][$];

  vreg_port_if #(.NUM_PORTS(NP), .ELEM_W(W)) bus ();

  vreg_port_responder #(
    .NUM_PORTS (NP),
    .ELEM_W    (W),
    .NUM_VREG  (8),
    .VLEN      (64)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .port_if (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input access_type_t t, input int len,
                         input stride_type_t s, input int vreg, input int addr, input int data);
    bus.req[p].vld           = 1'b1;
    bus.req[p].access_type   = t;
    bus.req[p].access_length = 32'(len);
    bus.req[p].stride_type   = s;
    bus.req[p].vec_reg_ptr   = v_register_t'(vreg);
    bus.req[p].addr          = 32'(addr);
    bus.req[p].data          = REQ_DATA_W'(data);
  endtask

  task automatic clr_req(input int p);
    bus.req[p] = '0;
  endtask

  task automatic expect_beat(input int p, input int at_cyc, input int data);
    exp_q[p].push_back({32'(at_cyc), W'(data)});
  endtask

  task automatic count_low(input int p, output int n);
    n = 0;
    while (bus.reg_req_grant[p] == 1'b0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (bus.reg_rsp_vld[p]) begin
        checks++;
        if (exp_q[p].size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected_p%0d actual=0x%0h@%0d required=no_beat",
                   p, bus.reg_rsp_data[p], cyc);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q[p].pop_front();
          if (bus.reg_rsp_data[p] !== e[W-1:0] || 32'(cyc) !== e[EXP_W-1:W]) begin
            failures++;
            $display("FAIL beat_p%0d actual=0x%0h@%0d required=0x%0h@%0d",
                     p, bus.reg_rsp_data[p], cyc, e[W-1:0], e[EXP_W-1:W]);
          end
        end
      end else begin
        checks++;
        if (bus.reg_rsp_data[p] !== '0) begin
          failures++;
          $display("FAIL idle_data_p%0d actual=0x%0h required=0x0", p, bus.reg_rsp_data[p]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int a;
    int n;
    for (int p = 0; p < NP; p++) clr_req(p);

    #3;
    chk("reset_grant", 32'({bus.reg_req_grant[1], bus.reg_req_grant[0]}), 32'h0);
    chk("reset_vld", 32'({bus.reg_rsp_vld[1], bus.reg_rsp_vld[0]}), 32'h0);
    chk("reset_busy", 32'(bus.port_busy), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("grant_before_first_edge", 32'(bus.reg_req_grant[0]), 32'h0);
    tick();
    chk("grant_after_release", 32'({bus.reg_req_grant[1], bus.reg_req_grant[0]}), 32'h3);

    // Write then single-beat read.
    set_req(0, WRITE_REQ, 1, NON_STRIDE, 2, 5, 'hA5);
    tick();
    clr_req(0);
    chk("write_keeps_grant", 32'(bus.reg_req_grant[0]), 32'h1);
    set_req(0, READ_REQ, 1, NON_STRIDE, 2, 5, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 'hA5);
    chk("single_grant_low", 32'(bus.reg_req_grant[0]), 32'h0);
    chk("single_busy", 32'(bus.port_busy), 32'h1);
    tick();
    chk("single_grant_back", 32'(bus.reg_req_grant[0]), 32'h1);

    // Preload v1[k] = k.
    for (int k = 0; k < 64; k++) begin
      set_req(0, WRITE_REQ, 0, NON_STRIDE, 1, k, k);
      tick();
    end
    clr_req(0);

    // Non-strided read wrapping past the end of the register.
    set_req(0, READ_REQ, 4, NON_STRIDE, 1, 62, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 62);
    expect_beat(0, a + 1, 63);
    expect_beat(0, a + 2, 0);
    expect_beat(0, a + 3, 1);
    count_low(0, n);
    chk("wrap_grant_low_cycles", 32'(n), 32'd4);

    // Strided read on port 1 concurrent with a single read on port 0.
    set_req(1, READ_REQ, 3, STRIDE, 1, 0, 3);
    set_req(0, READ_REQ, 1, NON_STRIDE, 2, 5, 0);
    tick();
    a = cyc;
    clr_req(0);
    clr_req(1);
    expect_beat(1, a, 0);
    expect_beat(1, a + 1, 3);
    expect_beat(1, a + 2, 6);
    expect_beat(0, a, 'hA5);
    count_low(1, n);
    chk("stride_grant_low_cycles", 32'(n), 32'd3);

    set_req(1, READ_REQ, 0, NON_STRIDE, 1, 10, 0);
    tick();
    a = cyc;
    clr_req(1);
    expect_beat(1, a, 10);
    count_low(1, n);
    chk("len0_grant_low_cycles", 32'(n), 32'd1);

    set_req(1, READ_REQ, 3, STRIDE, 1, 60, 5);
    tick();
    a = cyc;
    clr_req(1);
    expect_beat(1, a, 60);
    expect_beat(1, a + 1, 1);
    expect_beat(1, a + 2, 6);
    count_low(1, n);
    chk("stride_wrap_grant_low_cycles", 32'(n), 32'd3);

    // Length above VLEN; a write presented mid-burst must be ignored.
    set_req(0, READ_REQ, 66, NON_STRIDE, 1, 0, 0);
    tick();
    a = cyc;
    for (int i = 0; i < 66; i++) expect_beat(0, a + i, i % 64);
    set_req(0, WRITE_REQ, 0, NON_STRIDE, 1, 3, 'hEE);
    tick();
    tick();
    clr_req(0);
    count_low(0, n);
    chk("long_grant_low_cycles", 32'(n), 32'd64);

    // Same-cycle write collision: higher port wins.
    set_req(0, WRITE_REQ, 0, NON_STRIDE, 3, 7, 'h11);
    set_req(1, WRITE_REQ, 0, NON_STRIDE, 3, 7, 'h22);
    chk("collide_both_granted", 32'({bus.reg_req_grant[1], bus.reg_req_grant[0]}), 32'h3);
    tick();
    clr_req(0);
    clr_req(1);
    set_req(0, READ_REQ, 1, NON_STRIDE, 3, 7, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 'h22);
    tick();

    // Read beat coinciding with a write to the same element.
    set_req(1, WRITE_REQ, 0, NON_STRIDE, 4, 9, 'h44);
    tick();
    clr_req(1);
    set_req(0, READ_REQ, 1, NON_STRIDE, 4, 9, 0);
    tick();
    a = cyc;
    clr_req(0);
    set_req(1, WRITE_REQ, 0, NON_STRIDE, 4, 9, 'h33);
`ifdef VREG_WR_BYPASS_EN
    expect_beat(0, a, 'h33);
`else
    expect_beat(0, a, 'h44);
`endif
    tick();
    clr_req(1);
    set_req(0, READ_REQ, 1, NON_STRIDE, 4, 9, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 'h33);
    tick();

    // Reset during beat 2 of an 8-beat burst.
    set_req(0, READ_REQ, 8, NON_STRIDE, 1, 0, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 0);
    expect_beat(0, a + 1, 1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midburst_reset_vld", 32'(bus.reg_rsp_vld[0]), 32'h0);
    chk("midburst_reset_grant", 32'({bus.reg_req_grant[1], bus.reg_req_grant[0]}), 32'h0);
    chk("midburst_reset_busy", 32'(bus.port_busy), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rerelease_grant_before_edge", 32'(bus.reg_req_grant[0]), 32'h0);
    tick();
    chk("rerelease_grant_after_edge", 32'({bus.reg_req_grant[1], bus.reg_req_grant[0]}), 32'h3);

    set_req(0, READ_REQ, 1, NON_STRIDE, 1, 5, 0);
    set_req(1, READ_REQ, 1, NON_STRIDE, 3, 7, 0);
    tick();
    a = cyc;
    clr_req(0);
    clr_req(1);
    expect_beat(0, a, 0);
    expect_beat(1, a, 0);
    tick();
    set_req(0, READ_REQ, 1, NON_STRIDE, 2, 5, 0);
    tick();
    a = cyc;
    clr_req(0);
    expect_beat(0, a, 0);

    repeat (5) tick();
    chk("drain_port0", 32'(exp_q[0].size()), 32'd0);
    chk("drain_port1", 32'(exp_q[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vreg_port_responder.md
VREG_PORT_RESPONDER -- requirements
Module: vreg_port_responder

Interface
REQ-001 SHALL have parameter NUM_PORTS, default NUM_OF_LANES; number of independent request ports.
REQ-002 SHALL have parameter ELEM_W, default VECTOR_REG_WIDTH; element width in bits.
REQ-003 SHALL have parameter NUM_VREG, default NUM_OF_VECTOR_REG; number of vector registers, power of 2.
REQ-004 SHALL have parameter VLEN, default 64; elements per register, power of 2.
REQ-005 SHALL have port clk, input, 1; clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1; reset, asynchronous, active-low.
REQ-007 SHALL have port req, input, cntrl_req_t [NUM_PORTS]; per-port request (vld, access_type, access_length, stride_type, vec_reg_ptr, addr, data).
REQ-008 SHALL have port reg_req_grant, output, 1 [NUM_PORTS]; port ready to accept a request this cycle.
REQ-009 SHALL have port reg_rsp_vld, output, 1 [NUM_PORTS]; read beat valid.
REQ-010 SHALL have port reg_rsp_data, output, ELEM_W [NUM_PORTS]; read beat data.
REQ-011 SHALL have port port_busy, output, NUM_PORTS; bit i high while port i is in BURST.

Function
REQ-012 SHALL hold storage NUM_VREG x VLEN x ELEM_W; every port reads independently in the same cycle.
REQ-013 SHALL run one FSM per port with states IDLE and BURST; reg_req_grant[i] = (state==IDLE), combinational.
REQ-014 SHALL accept a request on port i in the cycle req[i].vld && reg_req_grant[i]; all request fields are captured at acceptance, and fields presented later are ignored until the port returns to IDLE.
REQ-015 SHALL treat WRITE_REQ as a single-element write of req.data[ELEM_W-1:0] to (vec_reg_ptr, addr mod VLEN) at the acceptance edge; the port stays IDLE and no response is returned.
REQ-016 SHALL treat READ_REQ as a burst: beat count N = access_length, with 0 treated as 1; the port enters BURST.
REQ-017 SHALL present the first read beat with reg_rsp_vld high exactly one cycle after acceptance, followed by one beat per cycle with no gaps, N beats total.
REQ-018 SHALL compute the element index as addr at beat 0, advancing by 1 for NON_STRIDE or by req.data[$clog2(VLEN)-1:0] for STRIDE; the index wraps modulo VLEN.
REQ-019 SHALL return the port from BURST to IDLE on the cycle the last beat is driven; reg_req_grant rises the following cycle.
REQ-020 SHALL drive reg_rsp_vld=0 and reg_rsp_data=0 on any cycle without a beat.
REQ-021 SHALL let the higher port index win when two or more ports write the same (register, element) in one cycle; all colliding writes are still granted.
REQ-022 SHALL use a 32-bit beat counter; access_length values above VLEN are legal and wrap the index.

Reset
REQ-023 SHALL, while reset is low, clear all storage to 0, force every FSM to IDLE, and drive reg_rsp_vld=0, reg_rsp_data=0, port_busy=0 and reg_req_grant=0.
REQ-024 SHALL abort any in-flight burst on reset assertion, with no further beats after release.
REQ-025 SHALL assert reg_req_grant on the first rising clk edge after reset deasserts.

Configuration
REQ-026 SHALL, with VREG_WR_BYPASS_EN defined, forward a same-cycle write to a read beat of the same (register, element), so the beat carries the new data.
REQ-027 SHALL, without VREG_WR_BYPASS_EN, return the pre-write value in that case; the new value is visible from the next cycle.

Structure
REQ-028 SHALL take cntrl_req_t, access type (READ_REQ/WRITE_REQ), stride type (NON_STRIDE/STRIDE), v_register_t, NUM_OF_LANES, VECTOR_REG_WIDTH and NUM_OF_VECTOR_REG from the shared package.
REQ-029 SHALL implement the per-port FSM, beat counter and index generator as sub-module vreg_port_fsm, instantiated NUM_PORTS times.

Verification
REQ-030 SHALL cover: after reset, port0 WRITE v2[5]=0xA5, then READ v2 addr 5 len 1 -> one beat 0xA5 exactly 1 cycle after acceptance; grant high again the following cycle.
REQ-031 SHALL cover: v1 preloaded with elements k=k, READ NON_STRIDE addr 62 len 4 (VLEN=64) -> back-to-back beats 62, 63, 0, 1; grant low for 4 cycles.
REQ-032 SHALL cover: READ STRIDE addr 0 data 3 len 3 -> beats from elements 0, 3, 6; access_length 0 -> exactly one beat.
REQ-033 SHALL cover: port0 writes v3[7]=0x11 and port1 writes v3[7]=0x22 in the same cycle -> both granted, later read returns 0x22.
REQ-034 SHALL cover: port0 reading v4[9] while port1 writes v4[9]=0x33 in the same cycle -> beat is 0x33 with VREG_WR_BYPASS_EN, old value without it.
REQ-035 SHALL cover: reset asserted mid-burst at beat 2 of 8 -> no further reg_rsp_vld, storage reads 0 afterwards, grant high on the first edge after release.
